snake_grid_render: RTL and testbench
====================================

SNAKE_GRID_RENDER -- requirements
Module: snake_grid_render

Interface
REQ-001 SHALL have parameter GRID_W, default 16, grid columns.
REQ-002 SHALL have parameter GRID_H, default 16, grid rows.
REQ-003 SHALL have parameter MAX_LEN, default 256, maximum snake segments.
REQ-004 SHALL derive POS_W = clog2(GRID_W*GRID_H) and LEN_W = clog2(MAX_LEN+1) as localparams.
REQ-005 SHALL have port clk  input  1  single clock, all logic on its rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port start  input  1  request to render one frame.
REQ-008 SHALL have port pos  input  MAX_LEN x POS_W  segment positions, pos[0] = head; caller holds it stable while busy.
REQ-009 SHALL have port length  input  LEN_W  number of valid segments.
REQ-010 SHALL have port food_pos  input  POS_W  food position.
REQ-011 SHALL have port busy  output  1  high from the cycle after start is accepted through COMMIT.
REQ-012 SHALL have port done  output  1  one-cycle pulse, frame committed.
REQ-013 SHALL have port grid  output  GRID_H x GRID_W  registered displayed frame.
REQ-014 SHALL have port self_hit  output  1  registered, last frame had overlapping segments.

Function
REQ-015 SHALL decode position p as row = p / GRID_W, col = p % GRID_W, cell bit grid[row][GRID_W-1-col].
REQ-016 SHALL implement FSM states IDLE, CLEAR, PAINT, FOOD, COMMIT.
REQ-017 SHALL, in IDLE with start high, latch min(length, MAX_LEN) and food_pos and enter CLEAR.
REQ-018 SHALL ignore start while not in IDLE.
REQ-019 SHALL, in CLEAR, zero the internal work buffer and segment index, then enter PAINT.
REQ-020 SHALL, in PAINT, set one work-buffer cell per cycle for pos[idx], idx from 0 to Lc-1 (Lc = latched clamped length), then enter FOOD.
REQ-021 SHALL treat Lc = 0 as a single PAINT cycle that paints nothing.
REQ-022 SHALL ignore any segment or food position >= GRID_W*GRID_H (no cell written, no hit).
REQ-023 SHALL, in FOOD, OR the food cell into the work buffer, then enter COMMIT.
REQ-024 SHALL, in COMMIT, copy the work buffer to grid, pulse done for one cycle, return to IDLE.
REQ-025 SHALL leave grid unchanged at all times except the COMMIT edge (double-buffered, no partial frames).
REQ-026 SHALL produce done max(Lc,1)+3 cycles after the edge that sampled start.
REQ-027 SHALL accept a new start in the cycle done is high (back-to-back frames).

Reset
REQ-028 SHALL, on reset_n low, asynchronously force state IDLE, grid all zero, work buffer zero, busy 0, done 0, self_hit 0, index 0.
REQ-029 SHALL, on reset mid-frame, discard the frame; grid stays zero until the next completed COMMIT.

Configuration
REQ-030 SHALL compile self-hit detection only when macro SNAKE_SELF_HIT_EN is defined.
REQ-031 SHALL, with SNAKE_SELF_HIT_EN, flag a hit when a PAINT cycle targets an already-set work cell; food is excluded; self_hit is loaded at COMMIT and holds until next COMMIT.
REQ-032 SHALL, without SNAKE_SELF_HIT_EN, tie self_hit to 0 and contain no detection logic.

Verification
REQ-033 SHALL test: defaults, length=3, pos={0x11,0x12,0x13}, food=0x80, start -> done at cycle 6, grid[1] bits 14,13,12 set, grid[8] bit 15 set, others 0.
REQ-034 SHALL test: length=0, food=0xFF, start -> done at cycle 4, only grid[15] bit 0 set.
REQ-035 SHALL test: SNAKE_SELF_HIT_EN, length=4, pos={0x22,0x23,0x33,0x22} -> self_hit=1 at done; rerun with pos[3]=0x32 -> self_hit=0.
REQ-036 SHALL test: start pulses while busy -> ignored, exactly one done, grid updates only on the COMMIT edge.
REQ-037 SHALL test: reset_n low during PAINT of a length=10 frame -> busy=0, grid=0 immediately, no done.
REQ-038 SHALL test: GRID_W=8, GRID_H=4, MAX_LEN=32, length=40, pos 0..31 sequential -> Lc=32, full grid set, done at cycle 35.

Source files
------------

// File: rtl/snake_grid_render.sv
// snake_grid_render: renders snake segments plus food into a double-buffered
// GRID_H x GRID_W bitmap. Define SNAKE_SELF_HIT_EN to build overlap detection.
module snake_grid_render #(
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 16,
    parameter int MAX_LEN = 256,
    localparam int POS_W  = $clog2(GRID_W * GRID_H),
    localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [MAX_LEN-1:0][POS_W-1:0] pos,
    input  logic [LEN_W-1:0]              length,
    input  logic [POS_W-1:0]              food_pos,
    output logic                          busy,
    output logic                          done,
    output logic [GRID_H-1:0][GRID_W-1:0] grid,
    output logic                          self_hit
);

    localparam int unsigned GW    = GRID_W;
    localparam int unsigned CELLS = GRID_W * GRID_H;
    localparam int          IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PAINT,
        FOOD,
        COMMIT
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] lc_q, lc_d;
    logic [POS_W-1:0] food_q, food_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CELLS-1:0] work_q, work_d;
    logic [CELLS-1:0] grid_q, grid_d;
    logic             done_q, done_d;
    logic [CELLS-1:0] seg_mask;
    logic             last_seg;

    // One-hot mask for a position; off-grid positions give an empty mask.
    function automatic logic [CELLS-1:0] cell_mask(input logic [POS_W-1:0] p);
        int unsigned pi;
        int unsigned r;
        int unsigned c;
        pi = 32'(p);
        r  = pi / GW;
        c  = pi % GW;
        cell_mask = '0;
        if (pi < CELLS) begin
            cell_mask = CELLS'(1) << (r * GW + (GW - 1 - c));
        end
    endfunction

    // Current segment mask and end-of-snake detection for PAINT.
    always_comb begin
        seg_mask = '0;
        if (LEN_W'(idx_q) < lc_q) begin
            seg_mask = cell_mask(pos[idx_q]);
        end
        last_seg = (LEN_W'(idx_q) + LEN_W'(1)) >= lc_q;
    end

    // Frame sequencer: next state and buffer updates.
    always_comb begin
        state_d = state_q;
        lc_d    = lc_q;
        food_d  = food_q;
        idx_d   = idx_q;
        work_d  = work_q;
        grid_d  = grid_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    lc_d    = (length > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : length;
                    food_d  = food_pos;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                work_d  = '0;
                idx_d   = '0;
                state_d = PAINT;
            end
            PAINT: begin
                work_d = work_q | seg_mask;
                if (last_seg) begin
                    state_d = FOOD;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            FOOD: begin
                work_d  = work_q | cell_mask(food_q);
                state_d = COMMIT;
            end
            COMMIT: begin
                grid_d  = work_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer and buffer registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            lc_q    <= '0;
            food_q  <= '0;
            idx_q   <= '0;
            work_q  <= '0;
            grid_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lc_q    <= lc_d;
            food_q  <= food_d;
            idx_q   <= idx_d;
            work_q  <= work_d;
            grid_q  <= grid_d;
            done_q  <= done_d;
        end
    end

`ifdef SNAKE_SELF_HIT_EN
    logic hit_q, hit_d;
    logic self_hit_q, self_hit_d;

    // Track segment overlap during PAINT and publish it with the frame.
    always_comb begin
        hit_d      = hit_q;
        self_hit_d = self_hit_q;
        if (state_q == CLEAR) begin
            hit_d = 1'b0;
        end
        if ((state_q == PAINT) && (|(work_q & seg_mask))) begin
            hit_d = 1'b1;
        end
        if (state_q == COMMIT) begin
            self_hit_d = hit_q;
        end
    end

    // Overlap registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_q      <= 1'b0;
            self_hit_q <= 1'b0;
        end else begin
            hit_q      <= hit_d;
            self_hit_q <= self_hit_d;
        end
    end

    assign self_hit = self_hit_q;
`else
    assign self_hit = 1'b0;
`endif

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign grid = grid_q;

endmodule

// File: tb/tb_snake_grid_render.sv
// tb_snake_grid_render: directed vectors for snake_grid_render,
// default 16x16 instance plus an 8x4 instance for length clamping.
`timescale 1ns/1ps
module tb_snake_grid_render;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset_n;
    logic                start;
    logic [255:0][7:0]   pos;
    logic [8:0]          length;
    logic [7:0]          food_pos;
    logic                busy;
    logic                done;
    logic [15:0][15:0]   grid;
    logic                self_hit;

    logic                s_start;
    logic [31:0][4:0]    s_pos;
    logic [5:0]          s_length;
    logic [4:0]          s_food;
    logic                s_busy;
    logic                s_done;
    logic [3:0][7:0]     s_grid;
    logic                s_self_hit;

    snake_grid_render u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .pos      (pos),
        .length   (length),
        .food_pos (food_pos),
        .busy     (busy),
        .done     (done),
        .grid     (grid),
        .self_hit (self_hit)
    );

    snake_grid_render #(
        .GRID_W  (8),
        .GRID_H  (4),
        .MAX_LEN (32)
    ) u_small (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (s_start),
        .pos      (s_pos),
        .length   (s_length),
        .food_pos (s_food),
        .busy     (s_busy),
        .done     (s_done),
        .grid     (s_grid),
        .self_hit (s_self_hit)
    );

    typedef struct {
        string            name;
        logic [8:0]       len;
        logic [3:0][7:0]  p;
        logic [7:0]       food;
        int               cyc;
        logic [15:0][15:0] g;
        logic             hit;
    } vec_t;

    vec_t vecs[6];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input string nm, input logic [8:0] len,
                           input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3,
                           input logic [7:0] food, input int cyc,
                           input logic hit);
        vecs[i].name = nm;
        vecs[i].len  = len;
        vecs[i].p[0] = p0;
        vecs[i].p[1] = p1;
        vecs[i].p[2] = p2;
        vecs[i].p[3] = p3;
        vecs[i].food = food;
        vecs[i].cyc  = cyc;
        vecs[i].hit  = hit;
        vecs[i].g    = '0;
    endtask

    // Start a frame on the default instance; cycles counted from the start edge.
    task automatic run_frame(input string nm, input logic [255:0] prev,
                             input int limit, output int cyc);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({nm, "_busy"}, 256'(busy), 256'(1));
        cyc = 0;
        while (cyc < limit) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) break;
            chk({nm, "_hold"}, grid, prev);
        end
    endtask

    initial begin
        int               cyc;
        int               dones;
        int               done_cyc;
        logic             exp_hit;
        logic [15:0][15:0] eg;

        set_vec(0, "len3",   9'd3, 8'h11, 8'h12, 8'h13, 8'h55, 8'h80, 6, 1'b0);
        vecs[0].g[1] = 16'h7000;
        vecs[0].g[8] = 16'h8000;
        set_vec(1, "len0",   9'd0, 8'h55, 8'h55, 8'h55, 8'h55, 8'hFF, 4, 1'b0);
        vecs[1].g[15] = 16'h0001;
        set_vec(2, "hit",    9'd4, 8'h22, 8'h23, 8'h33, 8'h22, 8'h00, 7, 1'b1);
        vecs[2].g[0] = 16'h8000;
        vecs[2].g[2] = 16'h3000;
        vecs[2].g[3] = 16'h1000;
        set_vec(3, "nohit",  9'd4, 8'h22, 8'h23, 8'h33, 8'h32, 8'h00, 7, 1'b0);
        vecs[3].g[0] = 16'h8000;
        vecs[3].g[2] = 16'h3000;
        vecs[3].g[3] = 16'h3000;
        set_vec(4, "foodov", 9'd2, 8'h00, 8'hFF, 8'h55, 8'h55, 8'h00, 5, 1'b0);
        vecs[4].g[0]  = 16'h8000;
        vecs[4].g[15] = 16'h0001;
        set_vec(5, "corner", 9'd1, 8'h0F, 8'h55, 8'h55, 8'h55, 8'hF0, 4, 1'b0);
        vecs[5].g[0]  = 16'h0001;
        vecs[5].g[15] = 16'h8000;

        reset_n  = 1'b0;
        start    = 1'b0;
        pos      = {256{8'h55}};
        length   = '0;
        food_pos = '0;
        s_start  = 1'b0;
        s_pos    = '0;
        s_length = '0;
        s_food   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grid", grid, '0);
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        chk("rst_hit", 256'(self_hit), 256'(0));
        chk("rst_sgrid", 256'(s_grid), 256'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            pos = {256{8'h55}};
            for (int k = 0; k < 4; k++) begin
                if (k < int'(vecs[i].len)) pos[k] = vecs[i].p[k];
            end
            length   = vecs[i].len;
            food_pos = vecs[i].food;
            run_frame(vecs[i].name, grid, 50, cyc);
            chk({vecs[i].name, "_cyc"}, 256'(cyc), 256'(vecs[i].cyc));
            chk({vecs[i].name, "_grid"}, grid, vecs[i].g);
`ifdef SNAKE_SELF_HIT_EN
            exp_hit = vecs[i].hit;
`else
            exp_hit = 1'b0;
`endif
            chk({vecs[i].name, "_selfhit"}, 256'(self_hit), 256'(exp_hit));
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_pulse"}, 256'(done), 256'(0));
            chk({vecs[i].name, "_idle"}, 256'(busy), 256'(0));
        end

        // Start pulses while busy are ignored; food is the latched value.
        pos      = {256{8'h55}};
        pos[0]   = 8'h00;
        pos[1]   = 8'h01;
        length   = 9'd2;
        food_pos = 8'h44;
        eg       = grid;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dones    = 0;
        done_cyc = 0;
        for (int c = 1; c <= 15; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                dones++;
                if (done_cyc == 0) done_cyc = c;
            end else if (c < 5) begin
                chk("busy_hold", grid, eg);
            end
            @(negedge clk);
            start    = (c <= 4) && (c % 2 == 1);
            food_pos = 8'h77;
            length   = 9'd9;
        end
        start = 1'b0;
        eg    = '0;
        eg[0] = 16'hC000;
        eg[4] = 16'h0800;
        chk("busy_dones", 256'(dones), 256'(1));
        chk("busy_cyc", 256'(done_cyc), 256'(5));
        chk("busy_grid", grid, eg);

        // Reset in the middle of painting a 10-segment frame.
        @(posedge clk);
        #1;
        pos = {256{8'h55}};
        for (int k = 0; k < 10; k++) pos[k] = 8'(k);
        length   = 9'd10;
        food_pos = 8'h00;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_busy", 256'(busy), 256'(0));
        chk("mid_grid", grid, '0);
        chk("mid_done", 256'(done), 256'(0));
        @(negedge clk);
        reset_n = 1'b1;
        dones   = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        chk("mid_nodone", 256'(dones), 256'(0));
        chk("mid_grid_stay", grid, '0);

        // Length clamp on the 8x4 instance.
        for (int k = 0; k < 32; k++) s_pos[k] = 5'(k);
        s_length = 6'd40;
        s_food   = 5'd0;
        @(negedge clk);
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        cyc     = 0;
        while (cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (s_done) break;
            chk("clamp_hold", 256'(s_grid), 256'(0));
        end
        chk("clamp_cyc", 256'(cyc), 256'(35));
        chk("clamp_grid", 256'(s_grid), 256'(32'hFFFF_FFFF));
        chk("clamp_hit", 256'(s_self_hit), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
